// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM states and slice width.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_lookahead_adder_4b.sv
// 4-bit carry-lookahead adder slice with group propagate/generate and signed overflow.
module carry_lookahead_adder_4b (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       Pg,
  output logic       Gg,
  output logic       overflow
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = A ^ B;
    g    = A & B;
    c[0] = C_in;
    c[1] = g[0] | (p[0] & C_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C_in);
    Gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    Pg   = &p;
    c[4] = Gg | (Pg & C_in);
    S        = p ^ c[3:0];
    // carry into the sign bit vs carry out of it
    overflow = c[4] ^ c[3];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit CLA slice, LSB nibble first.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             C_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             overflow
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] sl_a, sl_b, sl_s;
  logic             sl_pg, sl_gg, sl_ovf;

  assign sl_a = opa_q[idx_q*NIB_W +: NIB_W];
  assign sl_b = opb_q[idx_q*NIB_W +: NIB_W];

  carry_lookahead_adder_4b u_slice (
    .A       (sl_a),
    .B       (sl_b),
    .C_in    (carry_q),
    .S       (sl_s),
    .Pg      (sl_pg),
    .Gg      (sl_gg),
    .overflow(sl_ovf)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub | C_in;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[idx_q*NIB_W +: NIB_W] = sl_s;
        carry_d = sl_gg | (sl_pg & carry_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = carry_d;
          ovf_d   = sl_ovf;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign S        = s_q;
  assign C_out    = cout_q;
  assign overflow = ovf_q;

endmodule
